rvfi_commit_serializer: RTL and testbench

// - Sits between the core's multi-port RVFI commit interface and the per-hart RVFI trace writer.
// - Captures up to NR_COMMIT_PORTS retire/trap records per cycle into a FIFO.
// - Replays them one per cycle, in program order, over a valid/ready handshake.
// - Tags each output record with a monotonically increasing retirement order number.

---
 rtl/rvfi_commit_serializer.sv | 170 +++++++++++++++++
 tb/tb_rvfi_commit_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_serializer.sv
// Multi-port RVFI commit serializer: compacts per-cycle retire/trap records into a FIFO and replays them
// one per cycle with a retirement order tag. Optional stats outputs under RVFI_SERIALIZER_STATS_EN.
package rvfi_pkg;
    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [31:0]       insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [1:0]        mode;
        logic [1:0]        ixl;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned ORDER_W         = 64
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                       rvfi_o,
    output logic                                        valid_o,
    input  logic                                        ready_i,
    output logic [ORDER_W-1:0]                          order_o,
    output logic                                        overflow_o
`ifdef RVFI_SERIALIZER_STATS_EN
    ,
    output logic [31:0]                                 drop_count_o,
    output logic [$clog2(DEPTH):0]                      max_occ_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [ORDER_W-1:0]         r_order;
    logic                       r_overflow;
    rvfi_pkg::rvfi_instr_t      r_mem [DEPTH];

    logic [NR_COMMIT_PORTS-1:0] w_cap;
    logic [PTR_W-1:0]           w_wr_ptr [NR_COMMIT_PORTS];
    logic [PTR_W-1:0]           w_n;
    logic [PTR_W-1:0]           w_count;
    logic [PTR_W-1:0]           w_free;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_push;
    logic                       w_reject;
    logic                       w_pop;

    // Compaction: each captured port takes the next free slot after the lower-indexed captured ports.
    always_comb begin
        w_n = {PTR_W{1'b0}};
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            w_cap[i]    = rvfi_i[i].valid | rvfi_i[i].trap;
            w_wr_ptr[i] = r_wptr + w_n;
            if (w_cap[i]) begin
                w_n = w_n + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                w_n = w_n;
            end
        end
    end

    // Occupancy and atomic admission; free space excludes any pop happening this cycle.
    always_comb begin
        w_count  = r_wptr - r_rptr;
        w_empty  = (r_wptr == r_rptr);
        w_full   = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) && (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
        w_free   = PTR_W'(DEPTH) - w_count;
        w_push   = (w_n != {PTR_W{1'b0}}) && !w_full && (w_n <= w_free);
        w_reject = (w_n != {PTR_W{1'b0}}) && !w_push;
        w_pop    = !w_empty && ready_i;
    end

    // FIFO pointers, order counter and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= {PTR_W{1'b0}};
            r_rptr     <= {PTR_W{1'b0}};
            r_order    <= {ORDER_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_n;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
                r_order <= r_order + {{(ORDER_W-1){1'b0}}, 1'b1};
            end
            if (w_reject) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Record storage; contents are don't-care until written, empty reads are masked below.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (w_push && w_cap[i]) begin
                r_mem[w_wr_ptr[i][IDX_W-1:0]] <= rvfi_i[i];
            end
        end
    end

    // Show-ahead head record.
    always_comb begin
        if (w_empty) begin
            rvfi_o = '0;
        end else begin
            rvfi_o = r_mem[r_rptr[IDX_W-1:0]];
        end
        valid_o    = !w_empty;
        order_o    = r_order;
        overflow_o = r_overflow;
    end

`ifdef RVFI_SERIALIZER_STATS_EN
    logic [31:0]      r_drop_count;
    logic [PTR_W-1:0] r_max_occ;
    logic [32:0]      w_drop_sum;
    logic [PTR_W-1:0] w_count_next;

    // Post-update occupancy and saturating drop accumulation.
    always_comb begin
        w_drop_sum   = {1'b0, r_drop_count} + 33'(w_n);
        w_count_next = w_count + (w_push ? w_n : {PTR_W{1'b0}})
                       - {{(PTR_W-1){1'b0}}, w_pop};
    end

    // Drop counter and occupancy high-water mark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_count <= 32'd0;
            r_max_occ    <= {PTR_W{1'b0}};
        end else begin
            if (w_reject) begin
                r_drop_count <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
            end
            if (w_count_next > r_max_occ) begin
                r_max_occ <= w_count_next;
            end
        end
    end

    assign drop_count_o = r_drop_count;
    assign max_occ_o    = r_max_occ;
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Scoreboard bench for rvfi_commit_serializer: directed stimulus pushes expectations, a negedge monitor
// pops and compares each accepted output record.
module tb_rvfi_commit_serializer;
    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [63:0] pc;
        logic        trap;
    } exp_t;

    logic                             clk;
    logic                             rst_ni;
    rvfi_pkg::rvfi_instr_t [NP-1:0]   rvfi_i;
    rvfi_pkg::rvfi_instr_t            rvfi_o;
    logic                             valid_o;
    logic                             ready_i;
    logic [63:0]                      order_o;
    logic                             overflow_o;
`ifdef RVFI_SERIALIZER_STATS_EN
    logic [31:0]                      drop_count_o;
    logic [3:0]                       max_occ_o;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        q[$];
    logic [63:0] exp_order = 64'd0;
    logic        exp_ovf   = 1'b0;
    logic        held      = 1'b0;
    logic [63:0] held_pc;
    logic [63:0] held_order;
    exp_t        mon_e;

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .ORDER_W(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rvfi_i       (rvfi_i),
        .rvfi_o       (rvfi_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .order_o      (order_o),
        .overflow_o   (overflow_o)
`ifdef RVFI_SERIALIZER_STATS_EN
        ,
        .drop_count_o (drop_count_o),
        .max_occ_o    (max_occ_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one commit cycle; the model admits it atomically against the current occupancy.
    task automatic issue(input logic v0, input logic t0, input logic [63:0] pc0,
                         input logic v1, input logic t1, input logic [63:0] pc1);
        int   n;
        exp_t e;
        rvfi_i             = '0;
        rvfi_i[0].valid    = v0;
        rvfi_i[0].trap     = t0;
        rvfi_i[0].pc_rdata = pc0;
        rvfi_i[1].valid    = v1;
        rvfi_i[1].trap     = t1;
        rvfi_i[1].pc_rdata = pc1;
        n = int'(v0 | t0) + int'(v1 | t1);
        if (n <= int'(DEPTH) - q.size()) begin
            if (v0 | t0) begin e.pc = pc0; e.trap = t0; q.push_back(e); end
            if (v1 | t1) begin e.pc = pc1; e.trap = t1; q.push_back(e); end
        end else begin
            exp_ovf = 1'b1;
        end
        @(posedge clk); #1;
        rvfi_i = '0;
    endtask

    task automatic drain();
        int c;
        ready_i = 1'b1;
        c = 0;
        while ((q.size() != 0 || valid_o) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_timeout", 64'(c < 100), 64'd1);
        check("drain_valid_low", 64'(valid_o), 64'd0);
    endtask

    // Monitor: compare every transferred record, and hold-stability while stalled.
    always @(negedge clk) begin
        if (!rst_ni) begin
            held      = 1'b0;
            exp_order = 64'd0;
            q.delete();
        end else begin
            if (held) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_pc_stable", rvfi_o.pc_rdata, held_pc);
                check("stall_order_stable", order_o, held_order);
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got pc 0x%0h, expected no record", rvfi_o.pc_rdata);
                end else begin
                    mon_e = q.pop_front();
                    check("out_pc", rvfi_o.pc_rdata, mon_e.pc);
                    check("out_trap", 64'(rvfi_o.trap), 64'(mon_e.trap));
                    check("out_order", order_o, exp_order);
                    exp_order = exp_order + 64'd1;
                end
            end
            held       = valid_o && !ready_i;
            held_pc    = rvfi_o.pc_rdata;
            held_order = order_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni  = 1'b1;
        ready_i = 1'b0;
        rvfi_i  = '0;
        #1 rst_ni = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_rvfi_zero", 64'(rvfi_o == '0), 64'd1);
        check("rst_order", order_o, 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
`ifdef RVFI_SERIALIZER_STATS_EN
        check("rst_drop_count", 64'(drop_count_o), 64'd0);
        check("rst_max_occ", 64'(max_occ_o), 64'd0);
`endif
        @(posedge clk); #1 rst_ni = 1'b1;

        // Single record, one-cycle latency, then valid falls.
        ready_i = 1'b1;
        issue(1'b1, 1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        check("t1_valid_rise", 64'(valid_o), 64'd1);
        check("t1_pc", rvfi_o.pc_rdata, 64'h8000_0000);
        check("t1_order", order_o, 64'd0);
        @(negedge clk);
        check("t1_valid_fall", 64'(valid_o), 64'd0);
        @(posedge clk); #1;

        // Two records in one cycle, then port-1-only trap.
        issue(1'b1, 1'b0, 64'h100, 1'b1, 1'b0, 64'h104);
        drain();
        issue(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h200);
        drain();

        // Fill with ready low, then an overflowing 2-record cycle.
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 1'b0, 64'h400 + 64'(8 * k), 1'b1, 1'b0, 64'h404 + 64'(8 * k));
        end
        issue(1'b1, 1'b0, 64'hDEAD_0000, 1'b1, 1'b0, 64'hDEAD_0004);
        @(negedge clk);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_still_valid", 64'(valid_o), 64'd1);
        check("ovf_head_pc", rvfi_o.pc_rdata, 64'h400);
`ifdef RVFI_SERIALIZER_STATS_EN
        check("ovf_drop_count", 64'(drop_count_o), 64'd2);
        check("ovf_max_occ", 64'(max_occ_o), 64'd8);
`endif
        @(posedge clk); #1;
        drain();

        // Ready toggling against a continuous 2-per-cycle feed.
        for (int k = 0; k < 12; k++) begin
            ready_i = (k % 2 == 0);
            issue(1'b1, 1'b0, 64'h1000 + 64'(8 * k), 1'b1, 1'b0, 64'h1004 + 64'(8 * k));
        end
        drain();
        check("overflow_sticky", 64'(overflow_o), 64'(exp_ovf));

        // Reset with 5 entries queued.
        ready_i = 1'b0;
        issue(1'b1, 1'b0, 64'h2000, 1'b1, 1'b0, 64'h2004);
        issue(1'b1, 1'b0, 64'h2008, 1'b1, 1'b0, 64'h200C);
        issue(1'b1, 1'b0, 64'h2010, 1'b0, 1'b0, 64'h0);
        #1 rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_order", order_o, 64'd0);
        check("mid_rst_overflow", 64'(overflow_o), 64'd0);
        exp_ovf = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_ni = 1'b1;
        ready_i = 1'b1;
        issue(1'b1, 1'b0, 64'h3000, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        check("post_rst_order", order_o, 64'd0);
        @(posedge clk); #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
